// File: rtl/crm_slice_p_pkg.sv
// Shared types and helpers for the CRAM slice: FSM states, diag function codes, parity.
package crm_pkg;

    typedef enum logic [1:0] {IDLE, COMMIT, READ} crm_state_e;

    localparam int unsigned PAR_MAX_W = 64;

    // Diag codes sit directly above the field-load codes 0..NFIELD-1.
    function automatic int unsigned fn_commit(input int unsigned nfield);
        return nfield;
    endfunction

    function automatic int unsigned fn_clear(input int unsigned nfield);
        return nfield + 1;
    endfunction

    // Odd parity: 1 when the popcount is even. Zero-extension is parity-neutral.
    function automatic logic odd_par(input logic [PAR_MAX_W-1:0] v);
        return ~^v;
    endfunction

endpackage

// File: rtl/crm_slice_p_if.sv
// CRA/diag/EBUS signal bundle for the CRAM slice; master drives addresses and diag strobes.
interface crm_slice_p_if #(
    parameter int unsigned ADDR_W  = 11,
    parameter int unsigned NFIELD  = 4,
    parameter int unsigned FIELD_W = 4
);
    localparam int unsigned WORD_W = NFIELD * FIELD_W;
    localparam int unsigned SEL_W  = $clog2(NFIELD + 2);

    logic [ADDR_W-1:0]  cra_adr_h;
    logic [WORD_W-1:0]  crm_q_h;
    logic               cram_par_h;
    logic [SEL_W-1:0]   diag_sel_h;
    logic               diag_load_func_h;
    logic               diag_read_func_h;
    logic [FIELD_W-1:0] ebus_d_in_h;
    logic [FIELD_W-1:0] ebus_d_out_h;
    logic               ebus_d_oe_h;
    logic               crm_busy_h;
    logic               cram_par_err_h;

    modport master (
        output cra_adr_h, diag_sel_h, diag_load_func_h, diag_read_func_h, ebus_d_in_h,
        input  crm_q_h, cram_par_h, ebus_d_out_h, ebus_d_oe_h, crm_busy_h, cram_par_err_h
    );

    modport slave (
        input  cra_adr_h, diag_sel_h, diag_load_func_h, diag_read_func_h, ebus_d_in_h,
        output crm_q_h, cram_par_h, ebus_d_out_h, ebus_d_oe_h, crm_busy_h, cram_par_err_h
    );

endinterface

// File: rtl/crm_slice_p_ram.sv
// Single-port CRAM array: synchronous read with resettable output register, read-before-write.
module crm_ram_1p #(
    parameter int unsigned ADDR_W = 11,
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] wadr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] radr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wadr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else begin
            rdata <= mem[radr];
        end
    end

endmodule

// File: rtl/crm_slice_p.sv
// CRAM slice top: registered microword fetch plus EBUS diag load/commit/read-back FSM.
// Optional feature macro: CRM_PAR_CHECK_EN (stored parity bit, sticky parity error).
module crm_slice_p
    import crm_pkg::*;
#(
    parameter int unsigned ADDR_W  = 11,
    parameter int unsigned NFIELD  = 4,
    parameter int unsigned FIELD_W = 4
) (
    input logic          clk_crm_h,
    input logic          mr_reset_h,
    crm_slice_p_if.slave bus
);

    localparam int unsigned WORD_W = NFIELD * FIELD_W;
    localparam int unsigned SEL_W  = $clog2(NFIELD + 2);
    localparam logic [SEL_W-1:0] SEL_COMMIT = SEL_W'(fn_commit(NFIELD));
    localparam logic [SEL_W-1:0] SEL_CLEAR  = SEL_W'(fn_clear(NFIELD));
`ifdef CRM_PAR_CHECK_EN
    localparam int unsigned RAM_W = WORD_W + 1;
`else
    localparam int unsigned RAM_W = WORD_W;
`endif

    crm_state_e         state;
    logic [FIELD_W-1:0] hold     [NFIELD];
    logic [FIELD_W-1:0] hold_upd [NFIELD];
    logic [ADDR_W-1:0]  wadr;
    logic [FIELD_W-1:0] ebus_out;
    logic               ebus_oe;
    logic               busy;
    logic [WORD_W-1:0]  hold_word;
    logic [WORD_W-1:0]  crm_q;
    logic [FIELD_W-1:0] rd_field;
    logic               ram_we;
    logic [RAM_W-1:0]   ram_wdata;
    logic [RAM_W-1:0]   ram_rdata;

    // Holding-register image after a field-load or clear strobe, shared by IDLE and READ.
    always_comb begin
        for (int unsigned i = 0; i < NFIELD; i++) begin
            hold_upd[i] = hold[i];
            if (bus.diag_sel_h == SEL_CLEAR) begin
                hold_upd[i] = '0;
            end else if (bus.diag_sel_h == SEL_W'(i)) begin
                hold_upd[i] = bus.ebus_d_in_h;
            end
        end
    end

    always_comb begin
        hold_word = '0;
        for (int unsigned i = 0; i < NFIELD; i++) begin
            hold_word[i*FIELD_W +: FIELD_W] = hold[i];
        end
    end

    always_comb begin
        rd_field = '0;
        for (int unsigned i = 0; i < NFIELD; i++) begin
            if (bus.diag_sel_h == SEL_W'(i)) begin
                rd_field = crm_q[i*FIELD_W +: FIELD_W];
            end
        end
    end

    always_ff @(posedge clk_crm_h) begin
        if (mr_reset_h) begin
            state    <= IDLE;
            hold     <= '{default: '0};
            wadr     <= '0;
            ebus_out <= '0;
            ebus_oe  <= 1'b0;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // A load strobe of any code takes priority over a pending read request.
                    if (bus.diag_load_func_h) begin
                        if (bus.diag_sel_h == SEL_COMMIT) begin
                            wadr  <= bus.cra_adr_h;
                            busy  <= 1'b1;
                            state <= COMMIT;
                        end else begin
                            hold <= hold_upd;
                        end
                    end else if (bus.diag_read_func_h) begin
                        ebus_oe  <= 1'b1;
                        ebus_out <= rd_field;
                        state    <= READ;
                    end
                end
                COMMIT: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                READ: begin
                    if (bus.diag_load_func_h && bus.diag_sel_h != SEL_COMMIT) begin
                        hold <= hold_upd;
                    end
                    if (bus.diag_read_func_h) begin
                        ebus_oe  <= 1'b1;
                        ebus_out <= rd_field;
                    end else begin
                        ebus_oe  <= 1'b0;
                        ebus_out <= '0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Gating with reset lets a reset in the commit cycle abort the write.
    assign ram_we = (state == COMMIT) && !mr_reset_h;

    crm_ram_1p #(
        .ADDR_W (ADDR_W),
        .DATA_W (RAM_W)
    ) u_ram (
        .clk   (clk_crm_h),
        .rst   (mr_reset_h),
        .we    (ram_we),
        .wadr  (wadr),
        .wdata (ram_wdata),
        .radr  (bus.cra_adr_h),
        .rdata (ram_rdata)
    );

`ifdef CRM_PAR_CHECK_EN
    logic rd_valid;
    logic par_err;

    assign ram_wdata = {odd_par(PAR_MAX_W'(hold_word)), hold_word};
    assign crm_q     = ram_rdata[WORD_W-1:0];

    // The reset-cleared output register is not a real read, so it is not checked.
    always_ff @(posedge clk_crm_h) begin
        if (mr_reset_h) begin
            rd_valid <= 1'b0;
            par_err  <= 1'b0;
        end else begin
            rd_valid <= 1'b1;
            if (rd_valid && (ram_rdata[WORD_W] != odd_par(PAR_MAX_W'(crm_q)))) begin
                par_err <= 1'b1;
            end
        end
    end

    assign bus.cram_par_err_h = par_err;
`else
    assign ram_wdata          = hold_word;
    assign crm_q              = ram_rdata;
    assign bus.cram_par_err_h = 1'b0;
`endif

    assign bus.crm_q_h      = crm_q;
    assign bus.cram_par_h   = odd_par(PAR_MAX_W'(crm_q));
    assign bus.ebus_d_out_h = ebus_out;
    assign bus.ebus_d_oe_h  = ebus_oe;
    assign bus.crm_busy_h   = busy;

endmodule

// File: tb/tb_crm_slice_p.sv
// Randomised bench for crm_slice_p against a word-level memory/holding-register model.
module tb_crm_slice_p;

    localparam int unsigned ADDR_W  = 11;
    localparam int unsigned NFIELD  = 4;
    localparam int unsigned FIELD_W = 4;
    localparam int unsigned WORD_W  = NFIELD * FIELD_W;

    logic clk = 1'b0;
    logic rst = 1'b1;

    crm_slice_p_if #(.ADDR_W(ADDR_W), .NFIELD(NFIELD), .FIELD_W(FIELD_W)) bus ();

    crm_slice_p #(.ADDR_W(ADDR_W), .NFIELD(NFIELD), .FIELD_W(FIELD_W)) dut (
        .clk_crm_h  (clk),
        .mr_reset_h (rst),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    logic [WORD_W-1:0]  mem_m [int];
    logic [FIELD_W-1:0] hold_m [NFIELD];
    logic [WORD_W-1:0]  q_m;
    bit                 q_known = 1'b0;
    bit                 oe_m = 1'b0;
    logic [FIELD_W-1:0] out_m = '0;
    bit                 out_known = 1'b1;
    bit                 busy_m = 1'b0;
    bit                 reading_m = 1'b0;
    bit                 pend_m = 1'b0;
    int                 wadr_m = 0;

    function automatic logic [WORD_W-1:0] hold_word_m();
        logic [WORD_W-1:0] w = '0;
        for (int i = 0; i < NFIELD; i++) begin
            w = w | (WORD_W'(hold_m[i]) << (i * FIELD_W));
        end
        return w;
    endfunction

    function automatic logic [FIELD_W-1:0] field_of(input logic [WORD_W-1:0] w, input int sel);
        logic [WORD_W-1:0] t;
        if (sel >= NFIELD) return '0;
        t = w >> (sel * FIELD_W);
        return t[FIELD_W-1:0];
    endfunction

    task automatic model_hold(input int sel, input logic [FIELD_W-1:0] d);
        if (sel < NFIELD) begin
            hold_m[sel] = d;
        end else if (sel == NFIELD + 1) begin
            for (int i = 0; i < NFIELD; i++) hold_m[i] = '0;
        end
    endtask

    task automatic cycle(input bit r, input int adr, input int sel, input bit ld, input bit rd,
                         input logic [FIELD_W-1:0] d);
        logic [WORD_W-1:0] old_q;
        bit old_known;
        bit was_pend;
        rst                  = r;
        bus.cra_adr_h        = ADDR_W'(adr);
        bus.diag_sel_h       = 3'(sel);
        bus.diag_load_func_h = ld;
        bus.diag_read_func_h = rd;
        bus.ebus_d_in_h      = d;

        if (r) begin
            q_m = '0; q_known = 1'b1;
            oe_m = 1'b0; out_m = '0; out_known = 1'b1;
            busy_m = 1'b0; reading_m = 1'b0; pend_m = 1'b0;
            for (int i = 0; i < NFIELD; i++) hold_m[i] = '0;
        end else begin
            old_q     = q_m;
            old_known = q_known;
            was_pend  = pend_m;
            q_known   = mem_m.exists(adr);
            if (q_known) q_m = mem_m[adr];
            if (pend_m) begin
                mem_m[wadr_m] = hold_word_m();
                pend_m = 1'b0;
                busy_m = 1'b0;
            end
            if (was_pend) begin
                // commit cycle: strobes are ignored
            end else if (reading_m) begin
                if (ld && sel != NFIELD) model_hold(sel, d);
                if (rd) begin
                    oe_m = 1'b1; out_m = field_of(old_q, sel); out_known = old_known || sel >= NFIELD;
                end else begin
                    oe_m = 1'b0; out_m = '0; out_known = 1'b1; reading_m = 1'b0;
                end
            end else if (ld) begin
                if (sel == NFIELD) begin
                    pend_m = 1'b1; busy_m = 1'b1; wadr_m = adr;
                end else begin
                    model_hold(sel, d);
                end
            end else if (rd) begin
                reading_m = 1'b1; oe_m = 1'b1;
                out_m = field_of(old_q, sel); out_known = old_known || sel >= NFIELD;
            end
        end

        @(posedge clk);
        #1;
        if (q_known) begin
            check_val("q", 32'(bus.crm_q_h), 32'(q_m));
            check_val("par", 32'(bus.cram_par_h), 32'(($countones(q_m) % 2) == 0));
        end
        check_val("oe", 32'(bus.ebus_d_oe_h), 32'(oe_m));
        if (out_known) check_val("out", 32'(bus.ebus_d_out_h), 32'(out_m));
        check_val("busy", 32'(bus.crm_busy_h), 32'(busy_m));
`ifndef CRM_PAR_CHECK_EN
        check_val("par_err", 32'(bus.cram_par_err_h), 32'h0);
`endif
    endtask

    task automatic load_word(input logic [WORD_W-1:0] w, input int adr);
        for (int i = 0; i < NFIELD; i++) cycle(0, adr, i, 1, 0, field_of(w, i));
        cycle(0, adr, NFIELD, 1, 0, '0);
        check_val("busy_on_commit", 32'(bus.crm_busy_h), 32'h1);
        cycle(0, adr, 0, 0, 0, '0);
    endtask

    initial begin
        int adr;
        bit rd;

        // 1: reset
        cycle(1, 0, 0, 0, 0, '0);
        cycle(1, 0, 0, 0, 0, '0);
        check_val("t1_q", 32'(bus.crm_q_h), 32'h0);
        check_val("t1_par", 32'(bus.cram_par_h), 32'h1);
        check_val("t1_oe", 32'(bus.ebus_d_oe_h), 32'h0);
        check_val("t1_out", 32'(bus.ebus_d_out_h), 32'h0);
        check_val("t1_err", 32'(bus.cram_par_err_h), 32'h0);

        // 2: load 1,2,3,4 and commit at 0x123
        load_word(16'h4321, 'h123);
        cycle(0, 'h123, 0, 0, 0, '0);
        check_val("t2_q", 32'(bus.crm_q_h), 32'h4321);
        check_val("t2_par", 32'(bus.cram_par_h), 32'h0);

        // 3: read-back field 2
        cycle(0, 'h123, 2, 0, 1, '0);
        check_val("t3_oe", 32'(bus.ebus_d_oe_h), 32'h1);
        check_val("t3_out", 32'(bus.ebus_d_out_h), 32'h3);
        cycle(0, 'h123, 2, 0, 0, '0);
        check_val("t3_oe_off", 32'(bus.ebus_d_oe_h), 32'h0);
        check_val("t3_out_off", 32'(bus.ebus_d_out_h), 32'h0);

        // 4: simultaneous load and read
        cycle(0, 'h123, 0, 1, 1, 4'hF);
        check_val("t4_oe_first", 32'(bus.ebus_d_oe_h), 32'h0);
        cycle(0, 'h123, 0, 0, 1, '0);
        check_val("t4_oe_next", 32'(bus.ebus_d_oe_h), 32'h1);
        cycle(0, 'h123, 0, 0, 0, '0);
        cycle(0, 'h123, NFIELD, 1, 0, '0);
        cycle(0, 'h123, 0, 0, 0, '0);
        cycle(0, 'h123, 0, 0, 0, '0);
        check_val("t4_hold0", 32'(bus.crm_q_h), 32'h432F);

        // 5: reset during commit leaves 0x7FF unchanged
        cycle(0, 'h7FF, NFIELD, 1, 0, '0);
        cycle(0, 'h7FF, 0, 0, 0, '0);
        cycle(0, 'h7FF, 1, 1, 0, 4'hA);
        cycle(0, 'h7FF, NFIELD, 1, 0, '0);
        cycle(1, 'h7FF, 0, 0, 0, '0);
        cycle(0, 'h7FF, 0, 0, 0, '0);
        cycle(0, 'h7FF, 0, 0, 0, '0);
        check_val("t5_kept", 32'(bus.crm_q_h), 32'h432F);

        // Random traffic
        rd = 1'b0;
        for (int n = 0; n < 600; n++) begin
            case ($urandom_range(0, 4))
                0: adr = 'h123;
                1: adr = 'h7FF;
                2: adr = 'h010;
                default: adr = int'($urandom_range(0, 3));
            endcase
            if ($urandom_range(0, 3) == 0) rd = ~rd;
            cycle($urandom_range(0, 79) == 0, adr, int'($urandom_range(0, 7)),
                  $urandom_range(0, 3) == 0, rd, 4'($urandom));
        end

`ifdef CRM_PAR_CHECK_EN
        // 6: corrupted stored word raises a sticky parity error
        cycle(1, 'h010, 0, 0, 0, '0);
        load_word(16'hA5C3, 'h010);
        cycle(1, 'h010, 0, 0, 0, '0);
        cycle(1, 'h010, 0, 0, 0, '0);
        cycle(0, 'h010, 0, 0, 0, '0);
        cycle(0, 'h010, 0, 0, 0, '0);
        check_val("t6_clean", 32'(bus.cram_par_err_h), 32'h0);
        dut.u_ram.mem[16] = dut.u_ram.mem[16] ^ 17'h1;
        mem_m['h010] = mem_m['h010] ^ 16'h1;
        cycle(0, 'h010, 0, 0, 0, '0);
        cycle(0, 'h010, 0, 0, 0, '0);
        cycle(0, 'h010, 0, 0, 0, '0);
        check_val("t6_err", 32'(bus.cram_par_err_h), 32'h1);
        cycle(0, 'h123, 0, 0, 0, '0);
        cycle(0, 'h123, 0, 0, 0, '0);
        check_val("t6_sticky", 32'(bus.cram_par_err_h), 32'h1);
        cycle(1, 'h123, 0, 0, 0, '0);
        check_val("t6_reset", 32'(bus.cram_par_err_h), 32'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
